button_conditioner: RTL
=======================

# button_conditioner

Input front end for the snake game. It sits between the raw board push-buttons and the game top level, which consumes up/down/left/right/pause/restart as clean synchronous levels. Each raw button is synchronised, debounced and edge-detected. Direction presses are arbitrated to a single press pulse per cycle, and the pause button can be turned into a latched pause level.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive cycles a synchronised input must differ from its stable value before the change is accepted. Legal range is 2 to 2^20.

Ports:
- `clk`, input, 1: system clock, the same clock as the game.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `i_btn`, input, 6: raw asynchronous buttons, active-high. Bit 0 up, bit 1 down, bit 2 left, bit 3 right, bit 4 pause, bit 5 restart.
- `o_level`, output, 6: debounced stable level per button, same bit order.
- `o_press`, output, 6: one-cycle press pulse per button, after direction arbitration.
- `o_pause`, output, 1: pause level driving the game pause input.
- `o_restart`, output, 1: restart level driving the game restart input; equals `o_level[5]`.

## Operation

Per-bit pipeline, applied identically to all 6 bits:
- Two-flop synchroniser: `sync1`, then `sync2`.
- Counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`, and a `stable` bit.
- If `sync2 == stable`: `cnt <= 0`.
- Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2` and `cnt <= 0`.
- Else: `cnt <= cnt + 1`. The counter never wraps.
- A bounce, meaning `sync2` returning to `stable` before acceptance, clears `cnt`; the count then restarts from 0.

Raw press event:
- `rise[i]` is true when, at the edge where `stable[i]` goes 0 to 1, `stable[i]` becomes 1.
- It is registered, so it is visible in the same cycle `o_level[i]` first reads 1.

Direction arbitration, bits 0 to 3:
- Fixed priority: up > down > left > right.
- If several direction rises coincide in one cycle, only the highest-priority one pulses `o_press`.
- The losing directions' `o_level` bits still go high; their presses are dropped, not deferred.

Pause and restart presses pass straight through to `o_press[4]` and `o_press[5]`.

Release (stable 1 to 0) generates no pulse.

## Timing

Reset values (while `rst_n` is low):
- `sync1`, `sync2`, `stable`, `cnt` all 0.
- `o_level` = 0, `o_press` = 0, `o_pause` = 0, `o_restart` = 0.

Latency:
- Let edge 0 be the first edge that samples a new raw value, held steady from then on.
- `sync2` updates at edge 1.
- `cnt` reaches `DEBOUNCE_CYCLES-1` at edge `DEBOUNCE_CYCLES`.
- `o_level` and `o_press` change at edge `DEBOUNCE_CYCLES+1`.
- `o_press` is high for exactly one cycle.

Reset mid-count:
- Asserting `rst_n` low clears all state immediately, independent of `clk`.
- After deassertion, a button already held high is treated as a new press: the full latency applies and a press pulse is generated.

Outputs are all registered. There are no combinational paths from `i_btn`.

## Configuration

Macro `PAUSE_TOGGLE_EN`:
- Defined:
  - `o_pause` is a flop that toggles on every `o_press[4]`.
  - `o_press[5]` forces `o_pause <= 0`. This takes priority when both pulse in the same cycle.
  - `o_pause` resets to 0.
- Undefined:
  - `o_pause = o_level[4]`: the game pauses only while the button is held.
  - No toggle flop is instantiated.

## Test plan

Use `DEBOUNCE_CYCLES=4` throughout.

1. Clean press:
   - Stimulus: raise `i_btn[0]` before edge 0 and hold it.
   - Required: `o_level[0]` = 1 and `o_press[0]` = 1 after edge 5; `o_press[0]` = 0 after edge 6; `o_level[0]` stays 1.
2. Glitch rejection:
   - Stimulus: `i_btn[2]` high for 3 cycles, then low for 3, then high for 3, then low.
   - Required: `o_level[2]` and `o_press[2]` never assert.
3. Coincident directions:
   - Stimulus: raise `i_btn[1]` and `i_btn[3]` on the same cycle.
   - Required: `o_level` = 6'b001010; `o_press` pulses 6'b000010 only.
4. Release:
   - Stimulus: after scenario 1, drop `i_btn[0]`.
   - Required: `o_level[0]` = 0 after 6 edges; `o_press` stays 0.
5. Pause toggle (`PAUSE_TOGGLE_EN` defined):
   - Stimulus: two separate clean presses of bit 4, then one press of bit 5.
   - Required: `o_pause` reads 1, then 0 after the second press, then 0.
   - Repeat with `o_pause` set and bits 4 and 5 pressed simultaneously: `o_pause` = 0.
   - With the macro undefined: `o_pause` tracks `o_level[4]`.
6. Reset mid-count:
   - Stimulus: hold `i_btn[5]`, pulse `rst_n` low at edge 3, release reset.
   - Required: all outputs read 0 during reset; `o_restart` rises 5 edges after the first post-reset sampling edge, with `o_press[5]` = 1 for one cycle.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: 2-flop sync, debounce and rise detection for six board buttons,
// fixed-priority direction arbitration. Optional macro PAUSE_TOGGLE_EN latches pause.
`default_nettype none

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_btn,
  output logic [5:0] o_level,
  output logic [5:0] o_press,
  output logic       o_pause,
  output logic       o_restart
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [5:0] stable_vec;
  logic [5:0] rise_next;
  logic [3:0] dir_grant;
  logic [5:0] press;

  for (genvar i = 0; i < 6; i++) begin : g_bit
    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (sync2 != stable) && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1  <= 1'b0;
        sync2  <= 1'b0;
        stable <= 1'b0;
        cnt    <= '0;
      end else begin
        sync1 <= i_btn[i];
        sync2 <= sync1;
        // Any return to the stable value restarts the count, so bounces never accumulate.
        if (sync2 == stable) begin
          cnt <= '0;
        end else if (accept) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign stable_vec[i] = stable;
    // Rise is taken from the accepting edge so the pulse lands with the new level.
    assign rise_next[i]  = accept & sync2;
  end

  always_comb begin
    dir_grant = 4'b0000;
    if (rise_next[0])      dir_grant = 4'b0001;
    else if (rise_next[1]) dir_grant = 4'b0010;
    else if (rise_next[2]) dir_grant = 4'b0100;
    else if (rise_next[3]) dir_grant = 4'b1000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press <= 6'b000000;
    end else begin
      press <= {rise_next[5:4], dir_grant};
    end
  end

`ifdef PAUSE_TOGGLE_EN
  logic pause_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_q <= 1'b0;
    end else if (press[5]) begin
      pause_q <= 1'b0;
    end else if (press[4]) begin
      pause_q <= ~pause_q;
    end
  end

  assign o_pause = pause_q;
`else
  assign o_pause = stable_vec[4];
`endif

  assign o_level   = stable_vec;
  assign o_press   = press;
  assign o_restart = stable_vec[5];

endmodule

`default_nettype wire
